// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    // Bit positions inside the captured flag vector
    localparam int unsigned FLAG_OVF   = 3;
    localparam int unsigned FLAG_CARRY = 2;
    localparam int unsigned FLAG_NEG   = 1;
    localparam int unsigned FLAG_ZERO  = 0;

    // Highest select code the ALU implements
    localparam logic [3:0] MAX_SEL_DEFAULT = 4'd12;

    // Width of one queued command: {a, b, sel}
    localparam int unsigned CMD_W = 20;

    function automatic logic sel_is_legal(input logic [3:0] sel, input logic [3:0] max_sel);
        return sel <= max_sel;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB pointers for full/empty detection.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Handshaked one-op-at-a-time driver for the 8-bit combinational ALU.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned CMD_DEPTH     = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  MAX_SEL       = MAX_SEL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [7:0]      alu_a_n, alu_b_n;
    logic [3:0]      alu_sel_n;
    logic            rsp_valid_n, rsp_err_n;
    logic [7:0]      rsp_result_n;
    logic [3:0]      rsp_flags_n;
    logic [15:0]     op_count_n;
    logic            dispatch;
    logic            pop;
    logic            full, empty;
    logic [CMD_W-1:0] head;
    logic [7:0]      head_a, head_b;
    logic [3:0]      head_sel;

    alu_cmd_fifo #(
        .DEPTH(CMD_DEPTH),
        .WIDTH(CMD_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (cmd_valid),
        .pop  (pop),
        .wdata({cmd_a, cmd_b, cmd_sel}),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign {head_a, head_b, head_sel} = head;
    assign cmd_ready = !full;
    assign busy      = (state != IDLE) || !empty;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            alu_a      <= alu_a_n;
            alu_b      <= alu_b_n;
            alu_sel    <= alu_sel_n;
            rsp_valid  <= rsp_valid_n;
            rsp_result <= rsp_result_n;
            rsp_flags  <= rsp_flags_n;
            rsp_err    <= rsp_err_n;
            op_count   <= op_count_n;
        end
    end

    // Next-state logic; IDLE and a completed RESP share one dispatch path
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        alu_a_n      = alu_a;
        alu_b_n      = alu_b;
        alu_sel_n    = alu_sel;
        rsp_valid_n  = rsp_valid;
        rsp_result_n = rsp_result;
        rsp_flags_n  = rsp_flags;
        rsp_err_n    = rsp_err;
        op_count_n   = op_count;
        dispatch     = 1'b0;
        pop          = 1'b0;

        case (state)
            IDLE: dispatch = !empty;
            DRIVE: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    rsp_result_n             = alu_result;
                    rsp_flags_n[FLAG_OVF]    = alu_overflow;
                    rsp_flags_n[FLAG_CARRY]  = alu_carry;
                    rsp_flags_n[FLAG_NEG]    = alu_negative;
                    rsp_flags_n[FLAG_ZERO]   = alu_zero;
                    rsp_err_n                = 1'b0;
                    rsp_valid_n              = 1'b1;
                    state_n                  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    op_count_n  = op_count + 16'd1;
                    if (!empty) dispatch = 1'b1;
                    else        state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // An illegal dispatch re-raises rsp_valid, overriding the clear above
        if (dispatch) begin
            pop = 1'b1;
            if (sel_is_legal(head_sel, MAX_SEL)) begin
                alu_a_n   = head_a;
                alu_b_n   = head_b;
                alu_sel_n = head_sel;
                cnt_n     = SETTLE;
                state_n   = DRIVE;
            end else begin
                rsp_result_n = '0;
                rsp_flags_n  = '0;
                rsp_err_n    = 1'b1;
                rsp_valid_n  = 1'b1;
                state_n      = RESP;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: reference ALU, response model queue and directed scenarios.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_sel;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_result;
    logic        alu_zero, alu_negative, alu_carry, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [12:0] exp_q[$];
    int          hs_cyc[$];
    logic [15:0] mcount = '0;

    alu_cmd_sequencer #(
        .CMD_DEPTH(4),
        .SETTLE_CYCLES(1),
        .MAX_SEL(4'd12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: returns {ovf, carry, neg, zero, result}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (sel)
            4'd0: r = a & b;
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd2: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            default: r = a;
        endcase
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    // Expected response for a command: {err, flags, result}
    function automatic logic [12:0] model_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        if (sel > 4'd12) return {1'b1, 12'h000};
        return {1'b0, alu_fn(a, b, sel)};
    endfunction

    always_comb begin
        {alu_overflow, alu_carry, alu_negative, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_sel);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model; model updates follow the checks
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mcount = '0;
        end else begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0)
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            else if (rsp_valid)
                check("rsp_data", 32'({rsp_err, rsp_flags, rsp_result}), 32'(exp_q[0]));
            check("op_count", 32'(op_count), 32'(mcount));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                mcount = mcount + 16'd1;
                hs_cyc.push_back(cyc);
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back(model_rsp(cmd_a, cmd_b, cmd_sel));
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bit acc;
        int n;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        int n;
        done = 1'b0; n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && !rsp_valid;
            n++;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b0;

        // Model pins
        check("model_add", 32'(model_rsp(8'hCA, 8'h67, 4'd1)), 32'h0431);
        check("model_sub", 32'(model_rsp(8'h10, 8'h20, 4'd2)), 32'h06F0);
        check("model_ill", 32'(model_rsp(8'h10, 8'h20, 4'd13)), 32'h1000);

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_outputs", 32'({alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_flags, rsp_err, busy}), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single legal op
        push(8'hCA, 8'h67, 4'd1);
        @(posedge clk); #1;
        check("drive_ab", 32'({alu_a, alu_b}), 32'hCA67);
        check("drive_sel", 32'(alu_sel), 32'd1);
        check("drive_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_result", 32'(rsp_result), 32'h31);
        check("single_flags", 32'(rsp_flags), 32'b0100);
        check("single_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        wait_idle();
        rsp_ready = 1'b0;
        check("single_count", 32'(op_count), 32'd1);

        // Illegal select
        push(8'h11, 8'h22, 4'd13);
        @(posedge clk); #1;
        check("ill_valid", 32'(rsp_valid), 32'd1);
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_data", 32'({rsp_result, rsp_flags}), 32'd0);
        check("ill_alu_hold", 32'({alu_a, alu_b, alu_sel}), 32'hCA671);
        rsp_ready = 1'b1;
        wait_idle();

        // op_count wrap
        force dut.op_count = 16'hFFFF;
        mcount = 16'hFFFF;
        @(posedge clk); #1;
        release dut.op_count;
        push(8'h10, 8'h20, 4'd2);
        wait_idle();
        check("wrap_count", 32'(op_count), 32'd0);
        rsp_ready = 1'b0;

        // Reset mid-DRIVE with one command still queued
        push(8'hA5, 8'h5A, 4'd3);
        push(8'h33, 8'h44, 4'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_outputs", 32'({alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_flags, rsp_err, busy}), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("post_rst_quiet", 32'({busy, rsp_valid}), 32'd0);

        // Backpressure: fill FIFO plus one op parked in RESP
        for (int i = 0; i < 5; i++)
            push(8'(8'h03 + 8'(i) * 8'h11), 8'(8'h40 + 8'(i)), 4'(i));
        @(negedge clk);
        check("full_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        cmd_a = 8'h77; cmd_b = 8'h01; cmd_sel = 4'd5; cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("sixth_blocked", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        check("bp_count", 32'(op_count), 32'd5);
        rsp_ready = 1'b0;

        // Back-to-back responses from a preloaded FIFO
        push(8'h01, 8'h02, 4'd1);
        push(8'hF0, 8'h0F, 4'd3);
        push(8'h80, 8'h80, 4'd1);
        repeat (3) @(posedge clk); #1;
        hs_cyc.delete();
        rsp_ready = 1'b1;
        wait_idle();
        check("b2b_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            check("b2b_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
            check("b2b_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
        end
        check("b2b_op_count", 32'(op_count), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
